// File: rtl/mask_frame_streamer.sv
// mask_frame_streamer: classifies camera pixels into a 1-bit foreground mask,
// captures one full frame into on-chip memory, then replays it to the blob
// counter as a gap-free one-bit-per-clock stream behind a one-cycle start pulse.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | not armed, o_busy low
// S_WAIT_SOF  | armed, dropping pixels until the first SOF pixel
// S_CAPTURE   | writing mask bits; an early SOF restarts at address 0
// S_START     | one cycle: o_valid high, read of address 0 issued
// S_REPLAY    | o_seq carries one stored bit per cycle, no stalls
// S_WAIT_DONE | stream finished, holding until the blob counter reports done
module mask_frame_streamer #(
    parameter int IMG_COL = 640,
    parameter int IMG_ROW = 480,
    parameter int ADDR_W  = 19
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_pix_valid,
    input  logic        i_sof,
    input  logic [9:0]  i_r,
    input  logic [9:0]  i_g,
    input  logic [9:0]  i_b,
    input  logic [9:0]  i_thresh,
    input  logic        i_done,
    output logic        o_valid,
    output logic        o_seq,
    output logic        o_busy,
    output logic        o_restart
);

    localparam int                NPIX      = IMG_COL * IMG_ROW;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_START,
        S_REPLAY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_last_q, rd_last_d;
    logic [9:0]        thresh_q, thresh_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              restart_q, restart_d;

    logic [11:0]       luma_sum;
    logic [9:0]        cmp_thresh;
    logic              mask_bit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_re;
    logic              rd_bit_q;

    logic              mem [NPIX];

    // Luminance classification. Y = sum>>2 >= t is the same as sum >= 4t,
    // which avoids dropping the low sum bits. The SOF pixel uses the new
    // threshold directly since thresh_q only updates on that edge.
    always_comb begin
        luma_sum   = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
        cmp_thresh = i_sof ? i_thresh : thresh_q;
        mask_bit   = (luma_sum >= {cmp_thresh, 2'b00});
    end

    // Next-state, address counters and write/read strobes.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rd_last_d = rd_last_q;
        thresh_d  = thresh_q;
        restart_d = restart_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr_q;
        mem_re    = 1'b0;

        if (i_start) begin
            restart_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (i_pix_valid && i_sof) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_addr_d = ONE_ADDR;
                    thresh_d  = i_thresh;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (i_pix_valid) begin
                    mem_we = 1'b1;
                    if (i_sof) begin
                        mem_waddr = '0;
                        wr_addr_d = ONE_ADDR;
                        thresh_d  = i_thresh;
                        restart_d = 1'b1;
                    end else if (wr_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        rd_last_d = 1'b0;
                        state_d   = S_START;
                    end else begin
                        wr_addr_d = wr_addr_q + ONE_ADDR;
                    end
                end
            end
            // S_START issues the read of address 0; each following cycle
            // issues the next read until the last address has been read, and
            // the cycle after that (last bit on o_seq) moves on.
            S_START, S_REPLAY: begin
                if (rd_last_q) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    mem_re  = 1'b1;
                    state_d = S_REPLAY;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_last_d = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE_ADDR;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (i_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
            thresh_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rd_last_q <= rd_last_d;
            thresh_q  <= thresh_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            restart_q <= restart_d;
        end
    end

    // Mask memory: synchronous write, registered read, no reset so it maps
    // onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mask_bit;
        end
        if (mem_re) begin
            rd_bit_q <= mem[rd_addr_q];
        end
    end

    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_restart = restart_q;
    // The read register holds the last bit after replay; gating by state keeps
    // o_seq low everywhere outside S_REPLAY, including right after reset.
    assign o_seq     = rd_bit_q & (state_q == S_REPLAY);

endmodule

// File: tb/tb_mask_frame_streamer.sv
// Bench for mask_frame_streamer at reduced size (8x4). Expected mask bits are
// queued as pixels are driven and popped as the replay stream comes out.
module tb_mask_frame_streamer;

    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int NPIX = COLS * ROWS;
    localparam int AW   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic       done = 1'b0;
    logic [9:0] r = '0, g = '0, b = '0, thresh = '0;
    logic       valid_o, seq_o, busy_o, restart_o;

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_q[$];

    typedef struct {
        int r;
        int g;
        int b;
        int thr;
        bit exp;
    } vec_t;

    vec_t vecs[12];
    int   pr[NPIX], pg[NPIX], pb[NPIX];

    mask_frame_streamer #(
        .IMG_COL(COLS),
        .IMG_ROW(ROWS),
        .ADDR_W (AW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_pix_valid(pix_valid),
        .i_sof      (sof),
        .i_r        (r),
        .i_g        (g),
        .i_b        (b),
        .i_thresh   (thresh),
        .i_done     (done),
        .o_valid    (valid_o),
        .o_seq      (seq_o),
        .o_busy     (busy_o),
        .o_restart  (restart_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit model(input int pr_v, input int pg_v, input int pb_v, input int thr);
        return ((pr_v + 2 * pg_v + pb_v) / 4) >= thr;
    endfunction

    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    // Drives pixels first..first+count-1 from pr/pg/pb; pixel 0 carries SOF
    // and the frame threshold. force_exp < 0 queues the model bit, otherwise
    // queues force_exp. Returns at the negedge after the last accepted pixel.
    task automatic send_pixels(input int first, input int count, input int thr,
                               input int gap_pct, input int force_exp);
        for (int k = first; k < first + count; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                pix_valid = 1'b0;
                sof       = 1'($urandom_range(1));
                r         = 10'($urandom);
                g         = 10'($urandom);
                b         = 10'($urandom);
                thresh    = 10'($urandom);
            end
            @(negedge clk);
            pix_valid = 1'b1;
            sof       = (k == 0);
            r         = 10'(pr[k]);
            g         = 10'(pg[k]);
            b         = 10'(pb[k]);
            thresh    = (k == 0) ? 10'(thr) : 10'($urandom);
            if (k == 0) exp_q.delete();
            if (force_exp < 0) exp_q.push_back(model(pr[k], pg[k], pb[k], thr));
            else               exp_q.push_back(force_exp[0]);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Entered at the negedge one cycle after the last capture write.
    task automatic check_replay(input string tag, input int stop_at);
        bit e;
        int extra_valid;
        extra_valid = 0;
        check({tag, "_sb_depth"}, exp_q.size(), NPIX);
        check({tag, "_valid_pulse"}, valid_o, 1);
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            if (k == stop_at) return;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            check($sformatf("%s_bit%0d", tag, k), seq_o, e);
            if (valid_o) extra_valid++;
        end
        check({tag, "_valid_single"}, extra_valid, 0);
        @(negedge clk);
        check({tag, "_seq_after"}, seq_o, 0);
        check({tag, "_busy_waiting"}, busy_o, 1);
    endtask

    task automatic finish_done(input string tag);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check({tag, "_busy_after_done"}, busy_o, 0);
    endtask

    task automatic fill_uniform(input int rv, input int gv, input int bv);
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = rv;
            pg[k] = gv;
            pb[k] = bv;
        end
    endtask

    initial begin
        vecs[0]  = '{600, 600, 600, 512, 1'b1};
        vecs[1]  = '{511, 511, 511, 512, 1'b0};
        vecs[2]  = '{512, 512, 512, 512, 1'b1};
        vecs[3]  = '{1023, 1023, 1023, 512, 1'b1};
        vecs[4]  = '{1023, 1023, 1023, 1023, 1'b1};
        vecs[5]  = '{0, 0, 0, 0, 1'b1};
        vecs[6]  = '{0, 0, 0, 1, 1'b0};
        vecs[7]  = '{1, 1, 1, 1, 1'b1};
        vecs[8]  = '{1000, 0, 1023, 512, 1'b0};
        vecs[9]  = '{0, 1023, 1, 512, 1'b0};
        vecs[10] = '{0, 1023, 2, 512, 1'b1};
        vecs[11] = '{511, 512, 513, 512, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_seq", seq_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_restart", restart_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Uniform frames from the vector table, alternating gap density
        for (int v = 0; v < 12; v++) begin
            arm();
            fill_uniform(vecs[v].r, vecs[v].g, vecs[v].b);
            send_pixels(0, NPIX, vecs[v].thr, (v % 2) * 30, int'(vecs[v].exp));
            check_replay($sformatf("vec%0d", v), -1);
            if (v == 0) check("no_restart", restart_o, 0);
            finish_done($sformatf("vec%0d", v));
        end

        // Checkerboard with 50% valid gaps
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = (((k / COLS) + (k % COLS)) % 2 == 1) ? 1023 : 0;
            pg[k] = pr[k];
            pb[k] = pr[k];
        end
        arm();
        send_pixels(0, NPIX, 512, 50, -1);
        check_replay("checker", -1);
        finish_done("checker");

        // Early SOF after 20 pixels: only the second frame replays
        arm();
        fill_uniform(900, 900, 900);
        send_pixels(0, 20, 512, 0, -1);
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = (k % 3 == 0) ? 700 : 100;
            pg[k] = pr[k];
            pb[k] = pr[k];
        end
        send_pixels(0, NPIX, 400, 20, -1);
        check("restart_set", restart_o, 1);
        check_replay("early_sof", -1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_cleared", restart_o, 0);
        check("start_ignored_busy", busy_o, 1);
        finish_done("early_sof");

        // Overlap guard: pixels and i_start during replay and wait-done
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = (k % 5 < 2) ? 800 : 200;
            pg[k] = pr[k];
            pb[k] = pr[k];
        end
        arm();
        send_pixels(0, NPIX, 500, 0, -1);
        fork
            check_replay("overlap", -1);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    pix_valid = 1'b1;
                    sof       = 1'($urandom_range(1));
                    r         = 10'($urandom);
                    g         = 10'($urandom);
                    b         = 10'($urandom);
                    thresh    = 10'($urandom);
                    start     = 1'($urandom_range(1));
                end
                @(negedge clk);
                pix_valid = 1'b0;
                sof       = 1'b0;
                start     = 1'b0;
            end
        join
        @(negedge clk);
        check("overlap_hold_busy", busy_o, 1);
        check("overlap_hold_seq", seq_o, 0);
        check("overlap_hold_valid", valid_o, 0);
        @(negedge clk);
        done  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        start = 1'b0;
        check("done_start_busy", busy_o, 0);
        @(negedge clk);
        check("done_start_stays_idle", busy_o, 0);

        // Reset in the middle of replay, then a fresh frame
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = (k % 2 == 0) ? 1023 : 300;
            pg[k] = pr[k];
            pb[k] = pr[k];
        end
        arm();
        send_pixels(0, NPIX, 600, 0, -1);
        check_replay("pre_rst", 20);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_seq", seq_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy_o, 0);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        for (int k = 0; k < NPIX; k++) begin
            pr[k] = (k < 16) ? 50 : 950;
            pg[k] = pr[k];
            pb[k] = pr[k];
        end
        arm();
        send_pixels(0, NPIX, 512, 25, -1);
        check_replay("post_rst", -1);
        finish_done("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
